// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline hold/squash controller and the hazard
// detection logic of the 5-stage MIPS core:
//   - pipe_state_e : controller FSM state encoding
//   - NOP          : instruction word loaded into squashed pipeline registers
//   - OP_*         : primary opcode constants used by the hazard logic
//   - sat_inc8     : saturating 8-bit increment used by the hold watchdog
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } pipe_state_e;

    localparam logic [31:0] NOP = 32'b0;

    // MIPS primary opcodes (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Sticks at 255 so a very long hold can never wrap back past MAX_HOLD.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/stall_perf_cnt.sv
// stall_perf_cnt
// Free-running event counter: increments by one on every clock edge where
// inc_i is high, wraps modulo 2^CNT_W, clears on asynchronous reset.
// Ports:
//   clk     in   core clock
//   rst_n   in   asynchronous active-low reset
//   inc_i   in   count enable for this cycle
//   count_o out  current count (CNT_W bits)
module stall_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl
// Converts the per-cycle hazard decision and the EX-stage redirect into
// load enables and NOP-insert controls for PC, IF/ID and ID/EX. A redirect
// squashes FLUSH_LEN cycles; a hazard holds the front end, but never for
// more than MAX_HOLD consecutive cycles (watchdog release, sticky flag).
//
// Optional feature macro: STALL_PERF_CNT_EN
//   defined   -> stall_cycles / flush_cycles count cycles with pc_we=0 /
//                ifid_flush=1 (wrap modulo 2^CNT_W)
//   undefined -> both counter ports tied to 0, no counter flops
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   hazard        ID instruction must hold this cycle
//   flush_req     taken branch/jump resolved in EX this cycle
//   pc_we         PC load enable
//   ifid_we       IF/ID load enable
//   ifid_flush    load NOP into IF/ID
//   idex_bubble   load NOP into ID/EX
//   holding       FSM is in HOLD
//   hold_timeout  sticky: the watchdog has fired since reset
//   stall_cycles  cycles with pc_we = 0
//   flush_cycles  cycles with ifid_flush = 1
//   dbg_state     current FSM state, for observation only
module pipe_hold_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_LEN = 2,
    parameter int MAX_HOLD  = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard,
    input  logic             flush_req,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             holding,
    output logic             hold_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles,
    output pipe_state_e      dbg_state
);

    // fcnt holds the squash cycles still owed after the current one, minus
    // one; FLUSH_LEN <= 8 keeps it within 3 bits.
    localparam logic [2:0] FCNT_RELOAD = (FLUSH_LEN > 1) ? 3'(FLUSH_LEN - 2) : 3'd0;
    localparam logic [7:0] HOLD_LIMIT  = 8'(MAX_HOLD);

    pipe_state_e state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        timeout_q, timeout_d;

    logic pc_we_c, ifid_we_c, ifid_flush_c, idex_bubble_c;
    logic wd_release;

    // Watchdog only fires from HOLD, so a fresh hazard in RUN always stalls.
    assign wd_release = (state_q == HOLD) && (hold_cnt_q == HOLD_LIMIT) && hazard;

    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = timeout_q;
        pc_we_c       = 1'b1;
        ifid_we_c     = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;

        if (flush_req) begin
            // Redirect wins over everything, from any state.
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
            hold_cnt_d    = 8'd0;
            if (FLUSH_LEN > 1) begin
                state_d = FLUSH;
                fcnt_d  = FCNT_RELOAD;
            end else begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                FLUSH: begin
                    // Squashed instructions cannot raise a meaningful hazard.
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                    hold_cnt_d    = 8'd0;
                    if (fcnt_q == 3'd0) begin
                        state_d = RUN;
                    end else begin
                        fcnt_d = fcnt_q - 3'd1;
                    end
                end
                RUN, HOLD: begin
                    if (wd_release) begin
                        timeout_d  = 1'b1;
                        state_d    = RUN;
                        hold_cnt_d = 8'd0;
                    end else if (hazard) begin
                        pc_we_c       = 1'b0;
                        ifid_we_c     = 1'b0;
                        idex_bubble_c = 1'b1;
                        state_d       = HOLD;
                        hold_cnt_d    = sat_inc8(hold_cnt_q);
                    end else begin
                        state_d    = RUN;
                        hold_cnt_d = 8'd0;
                    end
                end
                default: begin
                    state_d    = RUN;
                    hold_cnt_d = 8'd0;
                    fcnt_d     = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fcnt_q     <= 3'd0;
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // While reset is low the front end is frozen and both stages load NOPs.
    assign pc_we        = rst_n & pc_we_c;
    assign ifid_we      = rst_n & ifid_we_c;
    assign ifid_flush   = ~rst_n | ifid_flush_c;
    assign idex_bubble  = ~rst_n | idex_bubble_c;
    assign holding      = rst_n & (state_q == HOLD);
    assign hold_timeout = timeout_q;
    assign dbg_state    = state_q;

`ifdef STALL_PERF_CNT_EN
    stall_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (~pc_we),
        .count_o (stall_cycles)
    );

    stall_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (ifid_flush),
        .count_o (flush_cycles)
    );
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Bench for pipe_hold_ctrl with FLUSH_LEN=3, MAX_HOLD=4: a directed vector
// table, hand sequences for watchdog and reset-in-HOLD, then random traffic
// checked against a cycle-count reference model.
module tb_pipe_hold_ctrl;

    localparam int FLUSH_LEN = 3;
    localparam int MAX_HOLD  = 4;
    localparam int CNT_W     = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             hazard = 1'b0;
    logic             flush_req = 1'b0;
    logic             pc_we, ifid_we, ifid_flush, idex_bubble;
    logic             holding, hold_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_cycles;
    logic [1:0]       dbg_state;

    pipe_hold_ctrl #(
        .FLUSH_LEN (FLUSH_LEN),
        .MAX_HOLD  (MAX_HOLD),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hazard       (hazard),
        .flush_req    (flush_req),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .holding      (holding),
        .hold_timeout (hold_timeout),
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Squash is tracked as "squash cycles still owed", a hold as the length
    // of the current run of stall cycles.
    int               m_squash_left;
    int               m_hold_run;
    bit               m_timeout;
    logic [CNT_W-1:0] m_stall, m_flush;
    bit               e_pc_we, e_ifid_we, e_ifid_flush, e_idex_bubble, e_holding;
    int               n_squash_left, n_hold_run;
    bit               n_timeout;

    function automatic logic [CNT_W-1:0] cnt_exp(input logic [CNT_W-1:0] v);
`ifdef STALL_PERF_CNT_EN
        return v;
`else
        return (v & '0);
`endif
    endfunction

    task automatic model_reset();
        m_squash_left = 0;
        m_hold_run    = 0;
        m_timeout     = 1'b0;
        m_stall       = '0;
        m_flush       = '0;
    endtask

    task automatic model_eval(input bit h, input bit f);
        n_squash_left = m_squash_left;
        n_hold_run    = m_hold_run;
        n_timeout     = m_timeout;
        e_holding     = (m_hold_run > 0);
        if (f || m_squash_left > 0) begin
            {e_pc_we, e_ifid_we, e_ifid_flush, e_idex_bubble} = 4'b1111;
            n_squash_left = f ? FLUSH_LEN - 1 : m_squash_left - 1;
            n_hold_run    = 0;
        end else if (h && m_hold_run == MAX_HOLD) begin
            {e_pc_we, e_ifid_we, e_ifid_flush, e_idex_bubble} = 4'b1100;
            n_timeout  = 1'b1;
            n_hold_run = 0;
        end else if (h) begin
            {e_pc_we, e_ifid_we, e_ifid_flush, e_idex_bubble} = 4'b0001;
            n_hold_run = (m_hold_run < 255) ? m_hold_run + 1 : 255;
        end else begin
            {e_pc_we, e_ifid_we, e_ifid_flush, e_idex_bubble} = 4'b1100;
            n_hold_run = 0;
        end
    endtask

    task automatic model_commit();
        if (!e_pc_we)     m_stall = m_stall + 1;
        if (e_ifid_flush) m_flush = m_flush + 1;
        m_squash_left = n_squash_left;
        m_hold_run    = n_hold_run;
        m_timeout     = n_timeout;
    endtask

    // ---------------- driver tasks ----------------
    // drive: inputs just after the edge, outputs settle before sampling.
    task automatic drive(input bit h, input bit f);
        hazard    = h;
        flush_req = f;
        #3;
        model_eval(h, f);
    endtask

    task automatic model_check(input string tag);
        chk({tag, "_pc_we"},        CNT_W'(pc_we),        CNT_W'(e_pc_we));
        chk({tag, "_ifid_we"},      CNT_W'(ifid_we),      CNT_W'(e_ifid_we));
        chk({tag, "_ifid_flush"},   CNT_W'(ifid_flush),   CNT_W'(e_ifid_flush));
        chk({tag, "_idex_bubble"},  CNT_W'(idex_bubble),  CNT_W'(e_idex_bubble));
        chk({tag, "_holding"},      CNT_W'(holding),      CNT_W'(e_holding));
        chk({tag, "_hold_timeout"}, CNT_W'(hold_timeout), CNT_W'(m_timeout));
        chk({tag, "_stall_cycles"}, stall_cycles,         cnt_exp(m_stall));
        chk({tag, "_flush_cycles"}, flush_cycles,         cnt_exp(m_flush));
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit h, f;
        bit pc_we, ifid_we, ifid_flush, idex_bubble, holding;
    } vec_t;

    vec_t vecs[20];

    initial begin
        // idle after reset
        for (int i = 0; i < 5; i++) vecs[i] = '{0, 0, 1, 1, 0, 0, 0};
        // two-cycle hazard
        vecs[5]  = '{1, 0, 0, 0, 0, 1, 0};
        vecs[6]  = '{1, 0, 0, 0, 0, 1, 1};
        vecs[7]  = '{0, 0, 1, 1, 0, 0, 1};
        vecs[8]  = '{0, 0, 1, 1, 0, 0, 0};
        // hazard together with redirect: squash, no HOLD
        vecs[9]  = '{1, 1, 1, 1, 1, 1, 0};
        vecs[10] = '{1, 0, 1, 1, 1, 1, 0};
        vecs[11] = '{1, 0, 1, 1, 1, 1, 0};
        vecs[12] = '{0, 0, 1, 1, 0, 0, 0};
        // redirect again in the second squash cycle: 4 squash cycles total
        vecs[13] = '{0, 1, 1, 1, 1, 1, 0};
        vecs[14] = '{0, 1, 1, 1, 1, 1, 0};
        vecs[15] = '{0, 0, 1, 1, 1, 1, 0};
        vecs[16] = '{0, 0, 1, 1, 1, 1, 0};
        vecs[17] = '{0, 0, 1, 1, 0, 0, 0};
        // hazard honoured straight after a squash
        vecs[18] = '{1, 0, 0, 0, 0, 1, 0};
        vecs[19] = '{0, 0, 1, 1, 0, 0, 1};
    end

    // ---------------- main sequence ----------------
    initial begin
        bit exp_pc;
        bit h_r, f_r;
        model_reset();

        // reset values while rst_n is low
        #12;
        chk("rst_pc_we",       CNT_W'(pc_we),        '0);
        chk("rst_ifid_we",     CNT_W'(ifid_we),      '0);
        chk("rst_ifid_flush",  CNT_W'(ifid_flush),   CNT_W'(1));
        chk("rst_idex_bubble", CNT_W'(idex_bubble),  CNT_W'(1));
        chk("rst_holding",     CNT_W'(holding),      '0);
        chk("rst_timeout",     CNT_W'(hold_timeout), '0);
        chk("rst_stall",       stall_cycles,         '0);
        chk("rst_flush",       flush_cycles,         '0);
        chk("rst_state",       CNT_W'(dbg_state),    '0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // table phase
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].h, vecs[i].f);
            chk($sformatf("vec%0d_pc_we", i),       CNT_W'(pc_we),       CNT_W'(vecs[i].pc_we));
            chk($sformatf("vec%0d_ifid_we", i),     CNT_W'(ifid_we),     CNT_W'(vecs[i].ifid_we));
            chk($sformatf("vec%0d_ifid_flush", i),  CNT_W'(ifid_flush),  CNT_W'(vecs[i].ifid_flush));
            chk($sformatf("vec%0d_idex_bubble", i), CNT_W'(idex_bubble), CNT_W'(vecs[i].idex_bubble));
            chk($sformatf("vec%0d_holding", i),     CNT_W'(holding),     CNT_W'(vecs[i].holding));
            chk($sformatf("vec%0d_timeout", i),     CNT_W'(hold_timeout), '0);
            model_check($sformatf("vec%0d_m", i));
            advance();
        end
        // table phase saw 3 stall cycles and 7 squash cycles
        chk("tbl_stall_total", stall_cycles, cnt_exp(CNT_W'(3)));
        chk("tbl_flush_total", flush_cycles, cnt_exp(CNT_W'(7)));

        // watchdog: hazard held 10 cycles
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b0);
            exp_pc = (i == 5) || (i == 10);
            chk($sformatf("wd%0d_pc_we", i),   CNT_W'(pc_we),        CNT_W'(exp_pc));
            chk($sformatf("wd%0d_timeout", i), CNT_W'(hold_timeout), CNT_W'(i >= 6));
            model_check($sformatf("wd%0d_m", i));
            advance();
        end
        drive(1'b0, 1'b0);
        chk("wd_after_timeout", CNT_W'(hold_timeout), CNT_W'(1));
        model_check("wd_after_m");
        advance();

        // reset pulse in the middle of a HOLD
        drive(1'b1, 1'b0);
        model_check("rh0");
        advance();
        drive(1'b1, 1'b0);
        chk("rh_holding_before", CNT_W'(holding), CNT_W'(1));
        rst_n = 1'b0;
        #1;
        chk("rh_pc_we",       CNT_W'(pc_we),        '0);
        chk("rh_ifid_we",     CNT_W'(ifid_we),      '0);
        chk("rh_ifid_flush",  CNT_W'(ifid_flush),   CNT_W'(1));
        chk("rh_idex_bubble", CNT_W'(idex_bubble),  CNT_W'(1));
        chk("rh_holding",     CNT_W'(holding),      '0);
        chk("rh_timeout",     CNT_W'(hold_timeout), '0);
        chk("rh_stall",       stall_cycles,         '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        drive(1'b0, 1'b0);
        chk("rh_state_run", CNT_W'(dbg_state), '0);
        model_check("rh_after");
        advance();

        // random phase against the model
        for (int i = 0; i < 400; i++) begin
            h_r = ($urandom_range(0, 99) < 60);
            f_r = ($urandom_range(0, 99) < 12);
            drive(h_r, f_r);
            model_check("rnd");
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
